// File: rtl/branch_predict_resolve.sv
// Branch predictor (direct-mapped BTB + 2-bit counters) and EX resolver.
// Predicts in IF, resolves and trains from EX outcomes.
module branch_predict_resolve #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_f_i,
  output logic            pred_taken_f_o,
  output logic [XLEN-1:0] pred_pc_f_o,
  input  logic            ex_valid_i,
  input  logic            ex_branch_i,
  input  logic            ex_stall_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_pc_i,
  input  logic            br_less_i,
  input  logic            br_equal_i,
  output logic            br_signed_o,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispred_cnt_o
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  logic [IDX-1:0]  f_idx, e_idx;
  logic [TAGW-1:0] f_tag, e_tag;
  logic            f_hit, e_hit;
  logic            taken, legal, act;
  logic [XLEN-1:0] next_pc;
  logic [1:0]      e_ctr;

  assign f_idx = pc_f_i[IDX+1:2];
  assign f_tag = pc_f_i[XLEN-1:IDX+2];
  assign e_idx = ex_pc_i[IDX+1:2];
  assign e_tag = ex_pc_i[XLEN-1:IDX+2];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign e_ctr = ctr_q[e_idx];

  assign pred_taken_f_o = f_hit && ctr_q[f_idx][1];
  assign pred_pc_f_o    = pred_taken_f_o ? target_q[f_idx]
                                         : pc_f_i + XLEN'(4);

  assign br_signed_o = ~ex_funct3_i[1];

  // Branch condition decode; 010/011 are not branches and fall through
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    unique case (ex_funct3_i)
      3'b000:  taken = br_equal_i;
      3'b001:  taken = ~br_equal_i;
      3'b100:  taken = br_less_i;
      3'b101:  taken = ~br_less_i;
      3'b110:  taken = br_less_i;
      3'b111:  taken = ~br_less_i;
      default: legal = 1'b0;
    endcase
  end

  assign act           = ex_valid_i && ex_branch_i && !ex_stall_i;
  assign next_pc       = taken ? ex_target_i : ex_pc_i + XLEN'(4);
  assign redirect_pc_o = next_pc;
  // Target compare alone catches both wrong direction and wrong target;
  // the carried-down direction bit is kept for pipeline visibility only.
  assign mispredict_o  = act && (next_pc != ex_pred_pc_i);

  logic unused;
  assign unused = ex_pred_taken_i;

  // Train BTB/BHT from resolved legal branches
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (act && legal) begin
      if (e_hit) begin
        if (taken) begin
          ctr_q[e_idx]    <= (e_ctr == 2'b11) ? e_ctr : e_ctr + 2'd1;
          target_q[e_idx] <= ex_target_i;
        end else begin
          ctr_q[e_idx]    <= (e_ctr == 2'b00) ? e_ctr : e_ctr - 2'd1;
        end
      end else if (taken) begin
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= ex_target_i;
        ctr_q[e_idx]    <= 2'b10;
      end
    end
  end

  // Saturating branch and mispredict statistics
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (act) begin
      if (branch_cnt_o != 32'hFFFF_FFFF)
        branch_cnt_o <= branch_cnt_o + 32'd1;
      if (mispredict_o && mispred_cnt_o != 32'hFFFF_FFFF)
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve.
// Vector table per cycle plus an async-reset sequence.
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_pc_f;
  logic        ex_valid, ex_branch, ex_stall;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target, ex_pred_pc;
  logic        ex_pred_taken;
  logic        br_less, br_equal;
  logic        br_signed, mispredict;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predict_resolve #(.XLEN(32), .ENTRIES(16)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .pc_f_i(pc_f),
    .pred_taken_f_o(pred_taken_f),
    .pred_pc_f_o(pred_pc_f),
    .ex_valid_i(ex_valid),
    .ex_branch_i(ex_branch),
    .ex_stall_i(ex_stall),
    .ex_funct3_i(ex_funct3),
    .ex_pc_i(ex_pc),
    .ex_target_i(ex_target),
    .ex_pred_taken_i(ex_pred_taken),
    .ex_pred_pc_i(ex_pred_pc),
    .br_less_i(br_less),
    .br_equal_i(br_equal),
    .br_signed_o(br_signed),
    .mispredict_o(mispredict),
    .redirect_pc_o(redirect_pc),
    .branch_cnt_o(branch_cnt),
    .mispred_cnt_o(mispred_cnt)
  );

  typedef struct {
    logic [31:0] pc_f;
    logic        act_v;
    logic        stall;
    logic [2:0]  f3;
    logic [31:0] epc;
    logic [31:0] tgt;
    logic [31:0] ppc;
    logic        lt;
    logic        eq;
    logic        x_taken;
    logic [31:0] x_ppc_f;
    logic        x_signed;
    logic        x_misp;
    logic [31:0] x_redir;
    logic [31:0] x_bcnt;
    logic [31:0] x_mcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic [31:0] pcf, logic av, logic st, logic [2:0] f3,
    logic [31:0] epc, logic [31:0] tgt, logic [31:0] ppc,
    logic lt, logic eq, logic xt, logic [31:0] xpf,
    logic xs, logic xm, logic [31:0] xr,
    logic [31:0] xb, logic [31:0] xc);
    vec_t v;
    v.pc_f = pcf; v.act_v = av; v.stall = st; v.f3 = f3;
    v.epc = epc; v.tgt = tgt; v.ppc = ppc; v.lt = lt; v.eq = eq;
    v.x_taken = xt; v.x_ppc_f = xpf; v.x_signed = xs;
    v.x_misp = xm; v.x_redir = xr; v.x_bcnt = xb; v.x_mcnt = xc;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    pc_f          = v.pc_f;
    ex_valid      = v.act_v;
    ex_branch     = v.act_v;
    ex_stall      = v.stall;
    ex_funct3     = v.f3;
    ex_pc         = v.epc;
    ex_target     = v.tgt;
    ex_pred_pc    = v.ppc;
    ex_pred_taken = (v.ppc != v.epc + 32'd4);
    br_less       = v.lt;
    br_equal      = v.eq;
  endtask

  task automatic check_vec(vec_t v, int i);
    check("pred_taken", i, {31'd0, pred_taken_f}, {31'd0, v.x_taken});
    check("pred_pc", i, pred_pc_f, v.x_ppc_f);
    check("br_signed", i, {31'd0, br_signed}, {31'd0, v.x_signed});
    check("mispredict", i, {31'd0, mispredict}, {31'd0, v.x_misp});
    check("redirect", i, redirect_pc, v.x_redir);
    check("branch_cnt", i, branch_cnt, v.x_bcnt);
    check("mispred_cnt", i, mispred_cnt, v.x_mcnt);
  endtask

  initial begin
    // pcf av st f3 epc tgt ppc lt eq | taken ppc_f sgn misp redir bcnt mcnt
    vecs.push_back(mk(32'h100,0,0,3'b000,32'h0,32'h0,32'h0,0,0,
                      0,32'h104,1,0,32'h4,0,0));
    vecs.push_back(mk(32'h100,1,0,3'b000,32'h100,32'h80,32'h104,0,1,
                      0,32'h104,1,1,32'h80,0,0));
    vecs.push_back(mk(32'h100,0,0,3'b000,32'h0,32'h0,32'h0,0,0,
                      1,32'h80,1,0,32'h4,1,1));
    vecs.push_back(mk(32'h100,1,0,3'b000,32'h100,32'h80,32'h80,0,0,
                      1,32'h80,1,1,32'h104,1,1));
    vecs.push_back(mk(32'h100,1,0,3'b000,32'h100,32'h80,32'h104,0,0,
                      0,32'h104,1,0,32'h104,2,2));
    vecs.push_back(mk(32'h100,0,0,3'b110,32'h200,32'h300,32'h0,1,0,
                      0,32'h104,0,0,32'h300,3,2));
    vecs.push_back(mk(32'h100,1,0,3'b000,32'h100,32'h90,32'h104,0,1,
                      0,32'h104,1,1,32'h90,3,2));
    vecs.push_back(mk(32'h100,1,0,3'b000,32'h100,32'h80,32'h90,0,1,
                      0,32'h104,1,1,32'h80,4,3));
    vecs.push_back(mk(32'h100,0,0,3'b000,32'h0,32'h0,32'h0,0,0,
                      1,32'h80,1,0,32'h4,5,4));
    vecs.push_back(mk(32'h100,1,1,3'b000,32'h100,32'h80,32'h80,0,0,
                      1,32'h80,1,0,32'h104,5,4));
    vecs.push_back(mk(32'h100,1,0,3'b010,32'h100,32'h80,32'h104,1,1,
                      1,32'h80,0,0,32'h104,5,4));
    vecs.push_back(mk(32'h100,0,0,3'b000,32'h0,32'h0,32'h0,0,0,
                      1,32'h80,1,0,32'h4,6,4));
    vecs.push_back(mk(32'h140,0,0,3'b000,32'h0,32'h0,32'h0,0,0,
                      0,32'h144,1,0,32'h4,6,4));
    vecs.push_back(mk(32'h140,1,0,3'b001,32'h140,32'h400,32'h144,0,0,
                      0,32'h144,1,1,32'h400,6,4));
    vecs.push_back(mk(32'h100,0,0,3'b000,32'h0,32'h0,32'h0,0,0,
                      0,32'h104,1,0,32'h4,7,5));
    vecs.push_back(mk(32'h140,0,0,3'b000,32'h0,32'h0,32'h0,0,0,
                      1,32'h400,1,0,32'h4,7,5));
    vecs.push_back(mk(32'hFFFF_FFFC,1,0,3'b101,32'hFFFF_FFFC,32'h40,32'h0,1,0,
                      0,32'h0,1,0,32'h0,7,5));
    vecs.push_back(mk(32'h104,1,0,3'b100,32'h104,32'h10,32'h108,1,0,
                      0,32'h108,1,1,32'h10,8,5));
    vecs.push_back(mk(32'h104,0,0,3'b000,32'h0,32'h0,32'h0,0,0,
                      1,32'h10,1,0,32'h4,9,6));

    drive(vecs[0]);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_vec(vecs[i], i);
    end

    // Reset asserted while a taken BGEU is pending: update must be lost
    @(negedge clk);
    drive(mk(32'h180,1,0,3'b111,32'h180,32'h500,32'h184,0,0,
             0,0,0,0,0,0,0));
    #1;
    check("pend_misp", 100, {31'd0, mispredict}, 32'd1);
    check("pend_signed", 100, {31'd0, br_signed}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_bcnt", 101, branch_cnt, 32'd0);
    check("rst_mcnt", 101, mispred_cnt, 32'd0);
    check("rst_ppc140", 101, pred_pc_f, 32'h184);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(32'h180,0,0,3'b000,32'h0,32'h0,32'h0,0,0,
             0,0,0,0,0,0,0));
    #1;
    check("post_taken", 102, {31'd0, pred_taken_f}, 32'd0);
    check("post_ppc", 102, pred_pc_f, 32'h184);
    pc_f = 32'h104;
    #1;
    check("post_ppc104", 103, pred_pc_f, 32'h108);
    check("post_bcnt", 103, branch_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
